// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared widths, default sizing and the buffered long-pipe entry layout for the
// write-back arbiter.
package e203_exu_wbck_arb_pkg;

  localparam int XLEN             = 32;
  localparam int RFIDX_W          = 5;
  localparam int FIFO_DEPTH_DEF   = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic               err;
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    wdat;
  } wbck_entry_t;

  localparam int ENTRY_W = $bits(wbck_entry_t);

  // x0 is hardwired to zero, so a write to it is always dropped
  function automatic logic rfWriteEna(input logic valid, input logic [RFIDX_W-1:0] rdidx);
    return valid & (rdidx != '0);
  endfunction

endpackage

// File: rtl/e203_wbck_fifo.sv
// Synchronous valid/ready FIFO with wrap-bit pointers and a registered occupancy
// count; DEPTH must be a power of two, at least 2.
module e203_wbck_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty = (wrPtr_q == rdPtr_q);
  assign push  = in_valid_i & ~full;
  assign pop   = out_ready_i & ~empty;

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign out_data_o  = mem_q[rdPtr_q[AW-1:0]];
  assign count_o     = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (pop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= in_data_i;
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Register-file write-back arbiter: buffered long-pipe results win over the ALU
// unless the ALU has starved. Optional same-cycle bypass: E203_WBCK_LONGP_BYPASS_EN.
module e203_exu_wbck_arb
  import e203_exu_wbck_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_wbck_i_valid,
  output logic                        alu_wbck_i_ready,
  input  logic [XLEN-1:0]             alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]          alu_wbck_i_rdidx,
  input  logic                        longp_wbck_i_valid,
  output logic                        longp_wbck_i_ready,
  input  logic [XLEN-1:0]             longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]          longp_wbck_i_rdidx,
  input  logic                        longp_wbck_i_err,
  output logic                        rf_wbck_o_ena,
  output logic [RFIDX_W-1:0]          rf_wbck_o_rdidx,
  output logic [XLEN-1:0]             rf_wbck_o_wdat,
  output logic [$clog2(FIFO_DEPTH):0] longp_pend_cnt
);

  localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  wbck_entry_t        enqEntry, headEntry;
  logic               fifoInValid, fifoInReady, headValid;
  logic               forceAlu, grantFifo, bypassLongp;
  logic [SC_W-1:0]    starveCnt_q, starveCnt_d;
  logic               rawEna;
  logic [RFIDX_W-1:0] muxIdx;
  logic [XLEN-1:0]    muxDat;

  assign enqEntry = '{err: longp_wbck_i_err, rdidx: longp_wbck_i_rdidx, wdat: longp_wbck_i_wdat};

  assign forceAlu         = alu_wbck_i_valid & (starveCnt_q == STARVE_MAX);
  assign grantFifo        = headValid & ~forceAlu;
  assign alu_wbck_i_ready = ~grantFifo & ~rst;

`ifdef E203_WBCK_LONGP_BYPASS_EN
  assign bypassLongp        = ~headValid & ~forceAlu & ~alu_wbck_i_valid & longp_wbck_i_valid;
  assign fifoInValid        = longp_wbck_i_valid & ~bypassLongp;
  assign longp_wbck_i_ready = fifoInReady | bypassLongp;
`else
  assign bypassLongp        = 1'b0;
  assign fifoInValid        = longp_wbck_i_valid;
  assign longp_wbck_i_ready = fifoInReady;
`endif

  e203_wbck_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (fifoInValid),
    .in_ready_o  (fifoInReady),
    .in_data_i   (enqEntry),
    .out_valid_o (headValid),
    .out_ready_i (grantFifo),
    .out_data_o  (headEntry),
    .count_o     (longp_pend_cnt)
  );

  always_comb begin
    rawEna = alu_wbck_i_valid;
    muxIdx = alu_wbck_i_rdidx;
    muxDat = alu_wbck_i_wdat;
    if (grantFifo) begin
      rawEna = ~headEntry.err;
      muxIdx = headEntry.rdidx;
      muxDat = headEntry.wdat;
    end else if (bypassLongp) begin
      rawEna = ~longp_wbck_i_err;
      muxIdx = longp_wbck_i_rdidx;
      muxDat = longp_wbck_i_wdat;
    end
  end

  // Reset suppresses the write combinationally so nothing lands in the reset cycle
  assign rf_wbck_o_ena   = rfWriteEna(rawEna, muxIdx) & ~rst;
  assign rf_wbck_o_rdidx = muxIdx;
  assign rf_wbck_o_wdat  = muxDat;

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (~alu_wbck_i_valid | alu_wbck_i_ready)
      starveCnt_d = '0;
    else if (grantFifo && (starveCnt_q != STARVE_MAX))
      starveCnt_d = starveCnt_q + SC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starveCnt_q <= '0;
    else     starveCnt_q <= starveCnt_d;
  end

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Table-driven bench for the write-back arbiter (default build, FIFO_DEPTH=2,
// STARVE_LIMIT=4), plus a hand-written reset-while-full sequence.
module tb_e203_exu_wbck_arb;

  typedef struct {
    logic        aV;
    logic [4:0]  aI;
    logic [31:0] aD;
    logic        lV;
    logic [4:0]  lI;
    logic [31:0] lD;
    logic        lE;
    logic        ena;
    logic [4:0]  idx;
    logic [31:0] dat;
    logic        aR;
    logic        lR;
    logic [1:0]  pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid, aluReady, longpValid, longpReady, longpErr, rfEna;
  logic [31:0] aluWdat, longpWdat, rfWdat;
  logic [4:0]  aluRdidx, longpRdidx, rfRdidx;
  logic [1:0]  pendCnt;

  int nVec  = 0;
  int nMiss = 0;

  vec_t vecs[21];

  always #5 clk = ~clk;

  e203_exu_wbck_arb dut (
    .clk                (clk),
    .rst                (rst),
    .alu_wbck_i_valid   (aluValid),
    .alu_wbck_i_ready   (aluReady),
    .alu_wbck_i_wdat    (aluWdat),
    .alu_wbck_i_rdidx   (aluRdidx),
    .longp_wbck_i_valid (longpValid),
    .longp_wbck_i_ready (longpReady),
    .longp_wbck_i_wdat  (longpWdat),
    .longp_wbck_i_rdidx (longpRdidx),
    .longp_wbck_i_err   (longpErr),
    .rf_wbck_o_ena      (rfEna),
    .rf_wbck_o_rdidx    (rfRdidx),
    .rf_wbck_o_wdat     (rfWdat),
    .longp_pend_cnt     (pendCnt)
  );

  function automatic vec_t mk(input logic aV, input logic [4:0] aI, input logic [31:0] aD,
                              input logic lV, input logic [4:0] lI, input logic [31:0] lD,
                              input logic lE, input logic ena, input logic [4:0] idx,
                              input logic [31:0] dat, input logic aR, input logic lR,
                              input logic [1:0] pend);
    vec_t v;
    v.aV = aV; v.aI = aI; v.aD = aD;
    v.lV = lV; v.lI = lI; v.lD = lD; v.lE = lE;
    v.ena = ena; v.idx = idx; v.dat = dat; v.aR = aR; v.lR = lR; v.pend = pend;
    return v;
  endfunction

  // Drives the inputs of one vector
  task automatic applyStimulus(input vec_t v);
    aluValid   = v.aV;
    aluRdidx   = v.aI;
    aluWdat    = v.aD;
    longpValid = v.lV;
    longpRdidx = v.lI;
    longpWdat  = v.lD;
    longpErr   = v.lE;
  endtask

  // Compares every output against the vector's expected values as one packed word
  task automatic checkOutput(input string name, input vec_t v);
    logic [41:0] act, exp;
    act = {rfEna, rfRdidx, rfWdat, aluReady, longpReady, pendCnt};
    exp = {v.ena, v.idx, v.dat, v.aR, v.lR, v.pend};
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got {ena,idx,dat,aluRdy,lpRdy,pend}=%h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, check before the next rising edge
  task automatic runVec(input string name, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(name, v);
  endtask

  task automatic driveOnly(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    // ALU alone, same-cycle write
    vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0, 0,         1, 5, 32'h1234, 1, 1, 0);
    vecs[1]  = idle;
    // Long-pipe entry wins the cycle after enqueue, ALU follows
    vecs[2]  = mk(1, 9, 32'h9999, 1, 7, 32'hA5A5, 0,  1, 9, 32'h9999, 1, 1, 0);
    vecs[3]  = mk(1, 10, 32'hAAAA, 0, 0, 0, 0,        1, 7, 32'hA5A5, 0, 1, 1);
    vecs[4]  = mk(1, 10, 32'hAAAA, 0, 0, 0, 0,        1, 10, 32'hAAAA, 1, 1, 0);
    vecs[5]  = idle;
    // Continuous feed starves the ALU for 4 cycles, granted on the 5th
    vecs[6]  = mk(0, 0, 0, 1, 1, 32'h11, 0,           0, 0, 0, 1, 1, 0);
    vecs[7]  = mk(1, 12, 32'hC0C0, 1, 2, 32'h22, 0,   1, 1, 32'h11, 0, 1, 1);
    vecs[8]  = mk(1, 12, 32'hC0C0, 1, 3, 32'h33, 0,   1, 2, 32'h22, 0, 1, 1);
    vecs[9]  = mk(1, 12, 32'hC0C0, 1, 4, 32'h44, 0,   1, 3, 32'h33, 0, 1, 1);
    vecs[10] = mk(1, 12, 32'hC0C0, 1, 5, 32'h55, 0,   1, 4, 32'h44, 0, 1, 1);
    vecs[11] = mk(1, 12, 32'hC0C0, 1, 6, 32'h66, 0,   1, 12, 32'hC0C0, 1, 1, 1);
    // FIFO now full: third push refused, accepted after a pop; counter restarted
    vecs[12] = mk(1, 14, 32'hE0E0, 1, 8, 32'h88, 0,   1, 5, 32'h55, 0, 0, 2);
    vecs[13] = mk(1, 14, 32'hE0E0, 1, 8, 32'h88, 0,   1, 6, 32'h66, 0, 1, 1);
    vecs[14] = mk(1, 14, 32'hE0E0, 0, 0, 0, 0,        1, 8, 32'h88, 0, 1, 1);
    vecs[15] = mk(1, 14, 32'hE0E0, 0, 0, 0, 0,        1, 14, 32'hE0E0, 1, 1, 0);
    vecs[16] = idle;
    // Errored long-pipe entry and an ALU write to x0: both consumed, no write
    vecs[17] = mk(0, 0, 0, 1, 3, 32'h3333, 1,         0, 0, 0, 1, 1, 0);
    vecs[18] = mk(1, 0, 32'h7777, 0, 0, 0, 0,         0, 3, 32'h3333, 0, 1, 1);
    vecs[19] = mk(1, 0, 32'h7777, 0, 0, 0, 0,         0, 0, 32'h7777, 1, 1, 0);
    vecs[20] = idle;

    rst = 1'b1;
    applyStimulus(idle);
    runVec("in_reset", mk(1, 5, 32'h1, 0, 0, 0, 0, 0, 5, 32'h1, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reach two pending entries via a forced ALU grant, then reset asynchronously
    driveOnly(mk(0, 0, 0, 1, 21, 32'h2100, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      driveOnly(mk(1, 22, 32'h2222, 1, 21, 32'h2100, 0, 0, 0, 0, 0, 0, 0));
    runVec("force_fill", mk(1, 22, 32'h2222, 1, 21, 32'h2100, 0, 1, 22, 32'h2222, 1, 1, 1));
    runVec("two_pending", mk(0, 0, 0, 0, 0, 0, 0, 1, 21, 32'h2100, 0, 0, 2));
    rst = 1'b1;
    #1;
    checkOutput("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0;
    runVec("post_reset0", idle);
    runVec("post_reset1", idle);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/e203_exu_wbck_arb.md
Name: e203_exu_wbck_arb

Overview:
Write-back arbiter that sits directly upstream of the general-purpose register file and drives its single write port (enable, index, data). It merges two producers: single-cycle ALU results and long-pipe results (LSU/MulDiv). Long-pipe results are buffered in a small FIFO and normally win arbitration. A starvation counter guarantees forward progress for the ALU.

Parameters:
- FIFO_DEPTH, 2, long-pipe result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive ALU-stalled cycles before the ALU is force-granted
- XLEN, 32, data width (matches E203_XLEN)
- RFIDX_W, 5, register index width (matches E203_RFIDX_WIDTH)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- alu_wbck_i_valid  in  1  ALU result valid
- alu_wbck_i_ready  out  1  ALU result accepted this cycle
- alu_wbck_i_wdat  in  XLEN  ALU result data
- alu_wbck_i_rdidx  in  RFIDX_W  ALU destination index
- longp_wbck_i_valid  in  1  long-pipe result valid
- longp_wbck_i_ready  out  1  long-pipe result accepted
- longp_wbck_i_wdat  in  XLEN  long-pipe data
- longp_wbck_i_rdidx  in  RFIDX_W  long-pipe destination
- longp_wbck_i_err  in  1  result faulted; consume without writing
- rf_wbck_o_ena  out  1  register-file write enable
- rf_wbck_o_rdidx  out  RFIDX_W  register-file write index
- rf_wbck_o_wdat  out  XLEN  register-file write data
- longp_pend_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, for dependency tracking

Behaviour:
- Reset (async on rst high): FIFO empty, pointers 0, starvation counter 0.
- Reset outputs: rf_wbck_o_ena=0, longp_pend_cnt=0, alu_wbck_i_ready=0.
- Handshakes use valid/ready. A transfer occurs when both are 1 at a rising edge.
- Valid must not depend on ready. Ready may depend on valid.
- longp_wbck_i_ready = !full. An enqueue stores {wdat, rdidx, err}.
- Arbitration each cycle, combinational:
  - head_v = FIFO not empty.
  - force_alu = alu_wbck_i_valid & (starve_cnt == STARVE_LIMIT).
  - grant_fifo = head_v & !force_alu.
  - alu_wbck_i_ready = !grant_fifo.
  - ALU ready is asserted whenever the FIFO has no grant, even if the ALU is not valid.
- Output mux:
  - grant_fifo: pop the head; drive rdidx/wdat from the head; ena = !head.err.
  - Otherwise: drive the ALU fields; ena = alu_wbck_i_valid.
- rf_wbck_o_ena is additionally forced 0 when rdidx==0. Data and index still mux normally.
- Register-file write occurs at the same edge as the handshake. Latency from source handshake to architectural update:
  - ALU: 0 cycles.
  - Long-pipe: ≥1 cycle (enqueue, then pop).
- Starvation counter:
  - Increments when alu_wbck_i_valid & grant_fifo; saturates at STARVE_LIMIT.
  - Clears on any ALU handshake, or when alu_wbck_i_valid=0.
- Error entries: popped normally, consume a grant, no write.
- Simultaneous enqueue and dequeue when full: not accepted. Ready depends only on registered full.
- Simultaneous enqueue and dequeue when not full: occupancy unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra wrap bit.
- longp_pend_cnt is registered and counts entries only.
- Reset mid-operation: buffered entries are discarded; no write is issued in the reset cycle.

Optional Feature:
- Macro: E203_WBCK_LONGP_BYPASS_EN.
- Defined:
  - When the FIFO is empty, force_alu=0 and alu_wbck_i_valid=0, an incoming long-pipe result bypasses the FIFO and writes the same cycle.
  - Bypass latency is 0; occupancy is unchanged.
  - In the bypass case, longp_wbck_i_ready = 1.
- Undefined: every long-pipe result is enqueued first, so the minimum long-pipe latency is 1 cycle.

Decomposition:
- Shared package/defines: XLEN, RFIDX_W, default FIFO depth, STARVE_LIMIT, and the entry layout {err, rdidx, wdat} with its width constant.
- One sub-module, e203_wbck_fifo: synchronous FIFO with valid/ready on both sides, an occupancy output and async active-high reset.
- Arbitration, the starvation counter and the output mux stay in the top.

Test Plan:
- ALU only: valid with rdidx=5, wdat=0x1234, FIFO empty → same cycle ena=1, rdidx=5, wdat=0x1234, alu ready=1.
- Long-pipe priority: enqueue rdidx=7, wdat=0xA5A5 while the ALU is valid → next cycle the FIFO writes x7; ALU ready=0; the ALU writes the following cycle.
- Full FIFO: three back-to-back long-pipe valids with no drain possible → third has ready=0 while longp_pend_cnt=2, and is accepted after the first pop.
- Starvation: keep the FIFO continuously fed while the ALU is valid → ALU granted on its 5th cycle (STARVE_LIMIT=4 stalls); counter returns to 0.
- Error/x0: long-pipe err=1 with rdidx=3, then an ALU write with rdidx=0 → both handshake, rf_wbck_o_ena stays 0, count decrements.
- Reset mid-stream: assert rst with 2 entries pending → ena=0 and longp_pend_cnt=0 immediately (async); no stale write after release.
